interrupt_controller: RTL and testbench

Edge-triggered, prioritised interrupt controller that sits directly on the CPU's IO interface and feeds the control unit's `io_interrupt` input. It synchronises external request lines into a pending register, gates them with a mask, and raises `io_interrupt`. On acknowledge it supplies the handler vector on `d_bus`. It also holds the saved return address across the handler.

---
 rtl/interrupt_controller.sv | 212 +++++++++++++++++++++
 tb/tb_interrupt_controller.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// Edge-triggered, prioritised interrupt controller on the CPU IO bus.
// Synchronises requests into PENDING, masks them, raises io_interrupt and serves the handler vector.
module interrupt_controller #(
    parameter int          NUM_IRQ   = 8,
    parameter logic [15:0] VEC_BASE  = 16'h0010,
    parameter int          VEC_SHIFT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               io_write,
    input  logic               io_push,
    input  logic               io_store_retaddr,
    input  logic               io_push_retaddr,
    input  logic               io_push_ints,
    input  logic               io_push_int_addr,
    input  logic [15:0]        d_addr,
    inout  wire logic [15:0]   d_bus,
    output logic               io_interrupt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SVC  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [NUM_IRQ-1:0] sync1_r;
    logic [NUM_IRQ-1:0] sync2_r;
    logic [NUM_IRQ-1:0] prev_r;
    logic [NUM_IRQ-1:0] pending_r;
    logic [NUM_IRQ-1:0] mask_r;
    logic               gen_r;
    logic [15:0]        retaddr_r;
    logic [2:0]         idx_r;
    logic [2:0]         idx_next_s;
    logic [2:0]         low_idx_s;
    logic [NUM_IRQ-1:0] rise_s;
    logic [NUM_IRQ-1:0] masked_s;
    logic [NUM_IRQ-1:0] clr_s;
    logic               ack_s;
    logic               wr_mask_s;
    logic               wr_pend_s;
    logic               wr_ctrl_s;
    logic [7:0]         mask8_s;
    logic [7:0]         pend8_s;
    logic [15:0]        idx_ext_s;
    logic [15:0]        vec_s;
    logic [15:0]        rd_data_s;
    logic               bus_en_s;
    logic [15:0]        bus_val_s;
    logic [11:0]        unused_addr_s;

    assign unused_addr_s = d_addr[15:4];
    assign rise_s        = sync2_r & ~prev_r;
    assign masked_s      = pending_r & mask_r;
    assign wr_mask_s     = io_write && (d_addr[3:0] == 4'd0);
    assign wr_pend_s     = io_write && (d_addr[3:0] == 4'd1);
    assign wr_ctrl_s     = io_write && (d_addr[3:0] == 4'd2);
    assign idx_ext_s     = {13'd0, idx_r};
    assign vec_s         = VEC_BASE + (idx_ext_s << VEC_SHIFT);

    // Lowest-numbered masked pending line wins.
    always_comb begin
        low_idx_s = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (masked_s[i]) begin
                low_idx_s = 3'(i);
            end else begin
                low_idx_s = low_idx_s;
            end
        end
    end

    // Zero-extended views of MASK and PENDING for the 16-bit bus.
    always_comb begin
        mask8_s                = 8'd0;
        pend8_s                = 8'd0;
        mask8_s[NUM_IRQ-1:0]   = mask_r;
        pend8_s[NUM_IRQ-1:0]   = pending_r;
    end

    // Next-state logic; a latched request stays committed until acknowledged.
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        ack_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (gen_r && (|masked_s)) begin
                    state_next_s = ST_REQ;
                    idx_next_s   = low_idx_s;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (io_push_int_addr) begin
                    state_next_s = ST_SVC;
                    ack_s        = 1'b1;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_SVC: begin
                if (io_push_retaddr) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_SVC;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Pending clears from W1C writes and acknowledge; a same-edge rise still wins below.
    always_comb begin
        clr_s = '0;
        if (wr_pend_s) begin
            clr_s = d_bus[NUM_IRQ-1:0];
        end else begin
            clr_s = '0;
        end
        if (ack_s) begin
            clr_s[idx_r] = 1'b1;
        end else begin
            clr_s = clr_s;
        end
    end

    // Request synchroniser, pending capture and edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r   <= '0;
            sync2_r   <= '0;
            prev_r    <= '0;
            pending_r <= '0;
        end else begin
            sync1_r   <= irq;
            sync2_r   <= sync1_r;
            prev_r    <= sync2_r;
            pending_r <= (pending_r & ~clr_s) | rise_s;
        end
    end

    // Software-visible configuration and saved return address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_r    <= '0;
            gen_r     <= 1'b0;
            retaddr_r <= 16'd0;
        end else begin
            if (wr_mask_s) begin
                mask_r <= d_bus[NUM_IRQ-1:0];
            end
            if (wr_ctrl_s) begin
                gen_r <= d_bus[0];
            end
            if (io_store_retaddr) begin
                retaddr_r <= d_bus;
            end
        end
    end

    // State register with io_interrupt registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            idx_r        <= 3'd0;
            io_interrupt <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            idx_r        <= idx_next_s;
            io_interrupt <= (state_next_s == ST_REQ);
        end
    end

    // Register read mux; unmapped addresses read zero.
    always_comb begin
        case (d_addr[3:0])
            4'd0:    rd_data_s = {8'd0, mask8_s};
            4'd1:    rd_data_s = {8'd0, pend8_s};
            4'd2:    rd_data_s = {15'd0, gen_r};
            default: rd_data_s = 16'd0;
        endcase
    end

    // Bus driver with fixed strobe priority.
    always_comb begin
        bus_en_s  = 1'b1;
        bus_val_s = 16'd0;
        if (io_push_int_addr) begin
            bus_val_s = vec_s;
        end else if (io_push_retaddr) begin
            bus_val_s = retaddr_r;
        end else if (io_push_ints) begin
            bus_val_s = {pend8_s, mask8_s};
        end else if (io_push) begin
            bus_val_s = rd_data_s;
        end else begin
            bus_en_s  = 1'b0;
            bus_val_s = 16'd0;
        end
    end

    assign d_bus = bus_en_s ? bus_val_s : 16'bz;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed scenarios followed by
// random traffic compared against a behavioural model of the controller.
module tb_interrupt_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  irq;
    logic        io_write, io_push, io_store_retaddr, io_push_retaddr;
    logic        io_push_ints, io_push_int_addr;
    logic [15:0] d_addr;
    logic        tb_drv;
    logic [15:0] tb_val;
    logic        io_interrupt;
    wire  [15:0] d_bus;

    int n_chk  = 0;
    int n_pass = 0;

    // Model state: pending/mask/gen/return address, serviced line and phase
    // (0 waiting, 1 requesting, 2 in handler), plus the last three irq samples.
    logic [7:0]  m_pend, m_mask, m_h1, m_h2, m_h3;
    logic        m_gen;
    logic [15:0] m_ret;
    int          m_idx, m_phase;

    assign d_bus = tb_drv ? tb_val : 16'hzzzz;
    pullup (d_bus);

    always #5 clk = ~clk;

    interrupt_controller dut (
        .clk(clk), .rst_n(rst_n), .irq(irq), .io_write(io_write), .io_push(io_push),
        .io_store_retaddr(io_store_retaddr), .io_push_retaddr(io_push_retaddr),
        .io_push_ints(io_push_ints), .io_push_int_addr(io_push_int_addr),
        .d_addr(d_addr), .d_bus(d_bus), .io_interrupt(io_interrupt)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    task automatic model_reset();
        m_pend = 8'h00; m_mask = 8'h00; m_gen = 1'b0; m_ret = 16'h0000;
        m_idx = 0; m_phase = 0; m_h1 = 8'h00; m_h2 = 8'h00; m_h3 = 8'h00;
    endtask

    function automatic logic [15:0] exp_reg(input logic [3:0] a);
        if (a == 4'd0) return {8'h00, m_mask};
        else if (a == 4'd1) return {8'h00, m_pend};
        else if (a == 4'd2) return {15'd0, m_gen};
        else return 16'h0000;
    endfunction

    function automatic logic [15:0] exp_bus();
        if (io_push_int_addr) return 16'h0010 + 16'(4 * m_idx);
        else if (io_push_retaddr) return m_ret;
        else if (io_push_ints) return {m_pend, m_mask};
        else if (io_push) return exp_reg(d_addr[3:0]);
        else return 16'hFFFF;
    endfunction

    // One rising edge of the model, using the inputs as they stand before the edge.
    task automatic model_edge();
        logic [7:0] rise, clr, live;
        int nphase, nidx;
        rise   = m_h2 & ~m_h3;
        live   = m_pend & m_mask;
        clr    = 8'h00;
        nphase = m_phase;
        nidx   = m_idx;
        if (io_write && d_addr[3:0] == 4'd1) clr = tb_val[7:0];
        if (m_phase == 0) begin
            if (m_gen && live != 8'h00) begin
                nphase = 1;
                for (int i = 7; i >= 0; i--) if (live[i]) nidx = i;
            end
        end else if (m_phase == 1) begin
            if (io_push_int_addr) begin
                nphase = 2;
                clr = clr | (8'h01 << m_idx);
            end
        end else begin
            if (io_push_retaddr) nphase = 0;
        end
        m_pend = (m_pend & ~clr) | rise;
        if (io_write && d_addr[3:0] == 4'd0) m_mask = tb_val[7:0];
        if (io_write && d_addr[3:0] == 4'd2) m_gen = tb_val[0];
        if (io_store_retaddr) m_ret = tb_val;
        m_h3 = m_h2; m_h2 = m_h1; m_h1 = irq;
        m_phase = nphase;
        m_idx = nidx;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk("io_interrupt", {15'd0, io_interrupt}, {15'd0, (m_phase == 1)});
    endtask

    task automatic clear_strobes();
        io_write = 1'b0; io_push = 1'b0; io_store_retaddr = 1'b0; io_push_retaddr = 1'b0;
        io_push_ints = 1'b0; io_push_int_addr = 1'b0; tb_drv = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] v);
        d_addr = a; tb_val = v; tb_drv = 1'b1; io_write = 1'b1;
        tick();
        clear_strobes();
    endtask

    task automatic ack(input string tag, input logic [15:0] expv);
        io_push_int_addr = 1'b1;
        #1 chk(tag, d_bus, expv);
        tick();
        clear_strobes();
    endtask

    task automatic ret(input string tag, input logic [15:0] expv);
        io_push_retaddr = 1'b1;
        #1 chk(tag, d_bus, expv);
        tick();
        clear_strobes();
    endtask

    task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] expv);
        io_push = 1'b1; d_addr = a;
        #1 chk(tag, d_bus, expv);
        io_push = 1'b0;
    endtask

    task automatic pulse(input logic [7:0] lines);
        irq = irq | lines;
        tick();
        irq = irq & ~lines;
    endtask

    initial begin
        rst_n = 1'b0; irq = 8'h00; d_addr = 16'h0000; tb_val = 16'h0000;
        clear_strobes();
        model_reset();
        @(posedge clk); #1;
        chk("reset_int", {15'd0, io_interrupt}, 16'h0000);
        chk("reset_hiz", d_bus, 16'hFFFF);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rd("reset_mask", 16'h0000, 16'h0000);
        rd("reset_pend", 16'h0001, 16'h0000);
        rd("reset_ctrl", 16'h0002, 16'h0000);

        // Single line latency, vector, acknowledge clears pending.
        wr(16'h0000, 16'h0004);
        wr(16'h0002, 16'h0001);
        rd("ctrl_rd", 16'h0002, 16'h0001);
        pulse(8'h04);
        tick(); tick();
        chk("lat3", {15'd0, io_interrupt}, 16'h0000);
        tick();
        chk("lat4", {15'd0, io_interrupt}, 16'h0001);
        ack("vec2", 16'h0018);
        chk("ack_fall", {15'd0, io_interrupt}, 16'h0000);
        rd("pend_clr", 16'h0001, 16'h0000);
        tb_drv = 1'b1; tb_val = 16'hBEEF; io_store_retaddr = 1'b1;
        tick();
        clear_strobes();
        ret("retaddr", 16'hBEEF);
        #1 chk("hiz", d_bus, 16'hFFFF);

        // Two lines rising together: lowest served first.
        wr(16'h0000, 16'h00FF);
        pulse(8'h22);
        tick(); tick(); tick();
        chk("two_req", {15'd0, io_interrupt}, 16'h0001);
        ack("vec1", 16'h0014);
        ret("ret1", 16'hBEEF);
        tick();
        chk("reraise5", {15'd0, io_interrupt}, 16'h0001);
        ack("vec5", 16'h0024);
        ret("ret5", 16'hBEEF);

        // Masked edge stays pending, unmasking raises one cycle later.
        wr(16'h0000, 16'h0000);
        pulse(8'h08);
        tick(); tick(); tick(); tick();
        chk("masked", {15'd0, io_interrupt}, 16'h0000);
        io_push_ints = 1'b1;
        #1 chk("status", d_bus, 16'h0800);
        io_push_ints = 1'b0;
        wr(16'h0010, 16'h0008);
        chk("unmask_e0", {15'd0, io_interrupt}, 16'h0000);
        tick();
        chk("unmask_e1", {15'd0, io_interrupt}, 16'h0001);
        ack("vec3", 16'h001C);
        ret("ret3", 16'hBEEF);

        // New edge on line 2 coincides with its acknowledge: set wins.
        wr(16'h0000, 16'h0004);
        pulse(8'h04);
        tick(); tick(); tick();
        pulse(8'h04);
        tick();
        ack("vec2b", 16'h0018);
        rd("set_wins", 16'h0001, 16'h0004);
        ret("ret2b", 16'hBEEF);
        tick();
        chk("reraise2", {15'd0, io_interrupt}, 16'h0001);
        ack("vec2c", 16'h0018);
        ret("ret2c", 16'hBEEF);

        // Reset while requesting.
        wr(16'h0000, 16'h0001);
        pulse(8'h01);
        tick(); tick(); tick();
        chk("pre_rst", {15'd0, io_interrupt}, 16'h0001);
        rst_n = 1'b0;
        #1 chk("rst_async", {15'd0, io_interrupt}, 16'h0000);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        rd("rst_mask", 16'h0000, 16'h0000);
        rd("rst_pend", 16'h0001, 16'h0000);
        rd("rst_ctrl", 16'h0002, 16'h0000);
        io_push_retaddr = 1'b1;
        #1 chk("rst_ret", d_bus, 16'h0000);
        io_push_retaddr = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("post_rst", {15'd0, io_interrupt}, 16'h0000);

        // Random traffic against the model.
        wr(16'h0002, 16'h0001);
        wr(16'h0000, 16'h00FF);
        for (int c = 0; c < 3000; c++) begin
            int sel;
            if ($urandom_range(0, 3) == 0) irq = irq ^ 8'($urandom);
            sel = $urandom_range(0, 11);
            case (sel)
                0: wr({12'($urandom), 4'($urandom_range(0, 4))}, 16'($urandom));
                1: begin
                    tb_drv = 1'b1; tb_val = 16'($urandom); io_store_retaddr = 1'b1;
                    tick();
                    clear_strobes();
                end
                2, 3, 4, 5, 6: begin
                    d_addr = {12'($urandom), 4'($urandom_range(0, 4))};
                    io_push          = (sel == 2);
                    io_push_ints     = (sel == 3);
                    io_push_int_addr = (sel == 4);
                    io_push_retaddr  = (sel == 5);
                    if (sel == 6) begin
                        {io_push, io_push_ints, io_push_int_addr, io_push_retaddr} = 4'($urandom);
                    end
                    #1 chk("rnd_bus", d_bus, exp_bus());
                    tick();
                    clear_strobes();
                end
                7: begin
                    #1 chk("rnd_hiz", d_bus, 16'hFFFF);
                    tick();
                end
                default: tick();
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
